// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the two writeback requester handshakes and the registered
//   register-file write port they share.
//   Req0*/Req1*   : valid/addr/data from the requester, ready back to it.
//   RegWrite, WriteRegister, WriteData : registered write port to the regfile.
//   master : requester / register-file side.  slave : the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Req0Valid;
  logic [ADDR_WIDTH-1:0] Req0Addr;
  logic [DATA_WIDTH-1:0] Req0Data;
  logic                  Req0Ready;
  logic                  Req1Valid;
  logic [ADDR_WIDTH-1:0] Req1Addr;
  logic [DATA_WIDTH-1:0] Req1Data;
  logic                  Req1Ready;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;

  modport master (
    output Req0Valid, Req0Addr, Req0Data, Req1Valid, Req1Addr, Req1Data,
    input  Req0Ready, Req1Ready, RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  Req0Valid, Req0Addr, Req0Data, Req1Valid, Req1Addr, Req1Data,
    output Req0Ready, Req1Ready, RegWrite, WriteRegister, WriteData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between execute writeback
//   (Req0) and load writeback (Req1) with round-robin tie breaking, and
//   sequences a bulk clear of registers 1..NUM_REGS-1, one per cycle.
// Ports:
//   RegClk, Reset  : clock, asynchronous active-high reset
//   wrBus          : requester handshakes + registered regfile write port
//   ClearReq       : pulse starting a bulk clear (ignored while clearing)
//   ClearBusy      : clear sequence in progress
//   ClearDone      : one-cycle pulse alongside the final clear write
//   ConflictCount  : saturating count of IDLE cycles with both requesters valid
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                   RegClk,
  input  logic                   Reset,
  regfile_write_arbiter_if.slave wrBus,
  input  logic                   ClearReq,
  output logic                   ClearBusy,
  output logic                   ClearDone,
  output logic [15:0]            ConflictCount
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so the counter can never wrap inside the sequence.
  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH+1)'(NUM_REGS-1);

  state_t                state;
  logic [ADDR_WIDTH:0]   clrCnt;
  logic                  lastGrant;  // 1: Req1 was granted last
  logic                  regWriteQ;
  logic [ADDR_WIDTH-1:0] writeRegQ;
  logic [DATA_WIDTH-1:0] writeDataQ;
  logic                  grant0, grant1, arbOpen, bothValid;

  // A clear request closes arbitration in the same cycle so no handshake
  // slips in ahead of the clear sequence.
  always_comb begin
    bothValid = wrBus.Req0Valid && wrBus.Req1Valid;
    arbOpen   = (state == IDLE) && !ClearReq;
    grant0    = arbOpen && wrBus.Req0Valid && (!wrBus.Req1Valid || lastGrant);
    grant1    = arbOpen && wrBus.Req1Valid && (!wrBus.Req0Valid || !lastGrant);
  end

  assign wrBus.Req0Ready     = grant0;
  assign wrBus.Req1Ready     = grant1;
  assign wrBus.RegWrite      = regWriteQ;
  assign wrBus.WriteRegister = writeRegQ;
  assign wrBus.WriteData     = writeDataQ;

  always_ff @(posedge RegClk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      clrCnt        <= '0;
      lastGrant     <= 1'b1;
      regWriteQ     <= 1'b0;
      writeRegQ     <= '0;
      writeDataQ    <= '0;
      ClearBusy     <= 1'b0;
      ClearDone     <= 1'b0;
      ConflictCount <= '0;
    end else begin
      regWriteQ <= 1'b0;
      ClearDone <= 1'b0;
      case (state)
        IDLE: begin
          if (bothValid && !ClearReq && ConflictCount != 16'hFFFF)
            ConflictCount <= ConflictCount + 16'd1;
          if (ClearReq) begin
            state     <= CLEAR;
            clrCnt    <= (ADDR_WIDTH+1)'(1);
            ClearBusy <= 1'b1;
          end else if (grant0) begin
            writeRegQ  <= wrBus.Req0Addr;
            writeDataQ <= wrBus.Req0Data;
            regWriteQ  <= (wrBus.Req0Addr != '0);  // r0 writes are dropped
            lastGrant  <= 1'b0;
          end else if (grant1) begin
            writeRegQ  <= wrBus.Req1Addr;
            writeDataQ <= wrBus.Req1Data;
            regWriteQ  <= (wrBus.Req1Addr != '0);
            lastGrant  <= 1'b1;
          end
        end
        CLEAR: begin
          regWriteQ  <= 1'b1;
          writeRegQ  <= clrCnt[ADDR_WIDTH-1:0];
          writeDataQ <= '0;
          clrCnt     <= clrCnt + 1'b1;
          if (clrCnt == LastIdx) begin
            ClearDone <= 1'b1;
            ClearBusy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic        RegClk = 1'b0;
  logic        Reset = 1'b0;
  logic        ClearReq = 1'b0;
  logic        ClearBusy, ClearDone;
  logic [15:0] ConflictCount;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .RegClk       (RegClk),
    .Reset        (Reset),
    .wrBus        (bus),
    .ClearReq     (ClearReq),
    .ClearBusy    (ClearBusy),
    .ClearDone    (ClearDone),
    .ConflictCount(ConflictCount)
  );

  always #5 RegClk = ~RegClk;

  // One entry per cycle in which the write-port registers get updated.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  wr_t sbQ[$];
  wr_t holdE;
  int  clearQ[$];     // clear indices still to issue
  int  mLast = 1;     // last granted requester
  int  mConf = 0;
  bit  monOn = 0;
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: the registered write port must show exactly the update
  // predicted for the previous edge, or hold its last value.
  initial begin
    wr_t e;
    forever begin
      @(negedge RegClk);
      if (monOn) begin
        if (sbQ.size() > 0) e = sbQ.pop_front();
        else e = '{1'b0, holdE.addr, holdE.data, 1'b0};
        holdE = e;
        chk("RegWrite", 64'(bus.RegWrite), 64'(e.we));
        chk("WriteRegister", 64'(bus.WriteRegister), 64'(e.addr));
        chk("WriteData", 64'(bus.WriteData), 64'(e.data));
        chk("ClearDone", 64'(ClearDone), 64'(e.done));
      end
    end
  end

  task automatic idleInputs();
    bus.Req0Valid = 0; bus.Req0Addr = '0; bus.Req0Data = '0;
    bus.Req1Valid = 0; bus.Req1Addr = '0; bus.Req1Data = '0;
    ClearReq = 0;
  endtask

  task automatic doReset();
    @(negedge RegClk);
    #2;
    Reset = 1'b1;
    idleInputs();
    #1;
    chk("rst RegWrite", 64'(bus.RegWrite), 64'd0);
    chk("rst WriteRegister", 64'(bus.WriteRegister), 64'd0);
    chk("rst WriteData", 64'(bus.WriteData), 64'd0);
    chk("rst ClearBusy", 64'(ClearBusy), 64'd0);
    chk("rst ClearDone", 64'(ClearDone), 64'd0);
    chk("rst ConflictCount", 64'(ConflictCount), 64'd0);
    sbQ.delete();
    clearQ.delete();
    holdE = '{1'b0, '0, '0, 1'b0};
    mLast = 1;
    mConf = 0;
    monOn = 1;
    repeat (2) @(posedge RegClk);
    @(negedge RegClk);
    #2;
    Reset = 1'b0;
  endtask

  // One cycle of stimulus plus the reference model's decision for it.
  task automatic cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic clr);
    logic e0, e1;
    @(negedge RegClk);
    bus.Req0Valid = v0; bus.Req0Addr = a0; bus.Req0Data = d0;
    bus.Req1Valid = v1; bus.Req1Addr = a1; bus.Req1Data = d1;
    ClearReq = clr;
    #1;
    e0 = 0;
    e1 = 0;
    chk("ClearBusy", 64'(ClearBusy), 64'(clearQ.size() > 0));
    chk("ConflictCount", 64'(ConflictCount), 64'(mConf));
    if (clearQ.size() > 0) begin
      int idx;
      idx = clearQ.pop_front();
      sbQ.push_back('{1'b1, AW'(idx), {DW{1'b0}}, logic'(clearQ.size() == 0)});
    end else if (clr) begin
      for (int i = 1; i < NR; i++) clearQ.push_back(i);
    end else begin
      if (v0 && v1) begin
        if (mConf < 65535) mConf++;
        e0 = (mLast == 1);
        e1 = !e0;
      end else begin
        e0 = v0;
        e1 = v1;
      end
      if (e0) begin
        mLast = 0;
        sbQ.push_back('{logic'(a0 != 0), a0, d0, 1'b0});
      end
      if (e1) begin
        mLast = 1;
        sbQ.push_back('{logic'(a1 != 0), a1, d1, 1'b0});
      end
    end
    chk("Req0Ready", 64'(bus.Req0Ready), 64'(e0));
    chk("Req1Ready", 64'(bus.Req1Ready), 64'(e1));
  endtask

  initial begin
    idleInputs();
    doReset();

    // single write
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // four-cycle tie: grants 0,1,0,1
    repeat (4) cycle(1, 1, 32'h1111, 1, 2, 32'h2222, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // register-0 write from Req1, then a tie
    cycle(0, 0, 0, 1, 0, 32'd7, 0);
    cycle(1, 3, 32'h33, 1, 4, 32'h44, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // clear with Req0 held valid; Req0 accepted in the ClearDone cycle
    cycle(1, 9, 32'hA5A5, 0, 0, 0, 1);
    repeat (31) cycle(1, 9, 32'hA5A5, 0, 0, 0, 0);
    cycle(1, 9, 32'hA5A5, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a clear
    cycle(0, 0, 0, 0, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0, 0, 0, 0);
    doReset();
    repeat (5) cycle(0, 0, 0, 0, 0, 0, 0);

    // random traffic with occasional clears
    repeat (3000) begin
      cycle(logic'($urandom_range(3) != 0), AW'($urandom), $urandom,
            logic'($urandom_range(3) != 0), AW'($urandom), $urandom,
            logic'($urandom_range(99) == 0));
    end
    repeat (40) cycle(0, 0, 0, 0, 0, 0, 0);

    // conflict counter saturation
    doReset();
    repeat (65540) cycle(1, AW'($urandom), $urandom, 1, AW'($urandom), $urandom, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    chk("ConflictCount sat", 64'(ConflictCount), 64'h0000_0000_0000_FFFF);

    repeat (2) @(negedge RegClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32-entry register file and shares it between two requesters: Req0 (execute writeback) and Req1 (load writeback).
- Uses valid/ready handshakes with round-robin arbitration and drives registered RegWrite/WriteRegister/WriteData into the register file.
- Also sequences a bulk-clear of registers 1..NUM_REGS-1 on command, one register per cycle.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register index.
- NUM_REGS, 32, number of register cells; clear sequence covers 1..NUM_REGS-1.

Ports:
- RegClk  input  1  clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Req0Valid  input  1  requester 0 has a write pending.
- Req0Addr  input  ADDR_WIDTH  requester 0 destination register.
- Req0Data  input  DATA_WIDTH  requester 0 write data.
- Req0Ready  output  1  requester 0 accepted this cycle (combinational).
- Req1Valid / Req1Addr / Req1Data / Req1Ready: same as above, for requester 1.
- ClearReq  input  1  single-cycle pulse that starts a bulk clear.
- ClearBusy  output  1  clear sequence in progress.
- ClearDone  output  1  one-cycle pulse when the final clear write is issued.
- RegWrite  output  1  write enable to the register file.
- WriteRegister  output  ADDR_WIDTH  register file write index.
- WriteData  output  DATA_WIDTH  register file write data.
- ConflictCount  output  16  saturating count of cycles where both requesters were valid in IDLE.

Behaviour:
- Reset (async, any time): state=IDLE; RegWrite=0, WriteRegister=0, WriteData=0; ClearBusy=0, ClearDone=0; ConflictCount=0; LastGrant=1, so Req0 wins the first tie. A clear in progress is abandoned.
- States: IDLE and CLEAR.
- IDLE arbitration, combinational each cycle:
  - Only one valid requester: it gets Ready.
  - Both valid: the requester other than LastGrant gets Ready, and only that one.
  - ReqNReady is never high without ReqNValid.
- A handshake is ReqNValid&&ReqNReady at a posedge. On that edge:
  - WriteRegister<=Addr, WriteData<=Data, LastGrant<=N.
  - RegWrite<=1 unless Addr==0. Register 0 writes are accepted and dropped: RegWrite<=0, LastGrant still updates.
- Edges with no handshake: RegWrite<=0. WriteRegister and WriteData hold their values.
- Latency: accepted at edge k → outputs valid after edge k → register file commits at edge k+1. Sustained throughput is one write per cycle.
- Conflict counting: in IDLE, both valid (ClearReq low) at an edge → ConflictCount+1, saturating at 16'hFFFF.
- ClearReq in IDLE:
  - Takes priority over pending requests. Both ReqNReady are forced low that cycle, so no handshake occurs.
  - At the edge: state<=CLEAR, counter<=1, ClearBusy<=1, RegWrite<=0.
- CLEAR state, each edge:
  - RegWrite<=1, WriteRegister<=counter, WriteData<=0, counter+1.
  - After issuing index NUM_REGS-1, ClearDone<=1 for one cycle, ClearBusy<=0, state<=IDLE.
  - Both Ready outputs are low for the entire CLEAR state; requesters hold Valid.
  - ClearReq is ignored while in CLEAR.
  - With NUM_REGS=32: ClearBusy is high for 31 cycles, 31 clear writes issue (indices 1..31), and ClearDone coincides with the WriteRegister=31 write.
- Returning to IDLE: arbitration resumes on the same edge that ClearDone is registered, so Ready may be high in the ClearDone cycle.
- Counter width is ADDR_WIDTH+1; no wrap-around is possible.

Test Plan:
- Reset, then Req0Valid=1, Addr=5, Data=32'hDEADBEEF for one handshake → one cycle after accept: RegWrite=1, WriteRegister=5, WriteData=DEADBEEF; next cycle RegWrite=0.
- Both valid for 4 consecutive cycles (Req0 Addr=1, Req1 Addr=2) → grant order 0,1,0,1; WriteRegister sequence 1,2,1,2; ConflictCount=4.
- Req1Valid, Addr=0, Data=7 → Req1Ready=1, RegWrite stays 0; the following tie grants Req0.
- ClearReq pulse with Req0Valid held high → Req0Ready=0 for 31 cycles; WriteRegister 1..31 with WriteData=0; ClearDone high exactly with index 31; Req0 accepted in the ClearDone cycle.
- Reset asserted mid-clear, at index 10 → all outputs 0 immediately; after deassert, IDLE with no further clear writes.
- Force 65536+ conflict cycles → ConflictCount holds at FFFF.
